// File: rtl/div_pkg.sv
// Shared types and constants for the 4-bit restoring serial divider.
package div_pkg;

    localparam int WIDTH = 4;
    localparam int ITERS = 4;
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    // True on the counter value at which the final quotient bit is produced.
    function automatic logic is_last_step(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(ITERS - 1);
    endfunction

endpackage

// File: rtl/four_bit_subtractor.sv
// Four-bit ripple-borrow subtractor: diff = a - b - bin, bout is the final borrow.
module four_bit_subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);

    logic [4:0] borrow;

    assign borrow[0] = bin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign diff[i]     = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign bout = borrow[4];

endmodule

// File: rtl/serial_divider_4bit.sv
// Restoring serial divider: one quotient bit per clock, results published on entry to DONE.
module serial_divider_4bit
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_e           state_q, state_d;
    logic [3:0]       q_q, q_d;
    logic [3:0]       r_q, r_d;
    logic [3:0]       d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       quot_q, quot_d;
    logic [3:0]       rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [3:0] step_s;
    logic [3:0] step_diff;
    logic       step_bout;
    logic       step_accept;
    logic [3:0] q_next;
    logic [3:0] r_next;

    // R[3] set means the true 5-bit partial remainder is >= 16 > D, so the
    // truncated difference is still correct and the step must be accepted.
    assign step_s      = {r_q[2:0], q_q[3]};
    assign step_accept = r_q[3] | ~step_bout;
    assign q_next      = {q_q[2:0], step_accept};
    assign r_next      = step_accept ? step_diff : step_s;

    four_bit_subtractor u_sub (
        .a    (step_s),
        .b    (d_q),
        .bin  (1'b0),
        .diff (step_diff),
        .bout (step_bout)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d   = dividend[3:0];
                    d_d   = divisor[3:0];
                    r_d   = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = 4'hF;
                        rem_d   = dividend[3:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                q_d   = q_next;
                r_d   = r_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (is_last_step(cnt_q)) begin
                    state_d = DONE;
                    quot_d  = q_next;
                    rem_d   = r_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == ITER);
    assign done        = (state_q == DONE);
    assign quotient    = WIDTH'(quot_q);
    assign remainder   = WIDTH'(rem_q);
    assign div_by_zero = dbz_q;

endmodule
